// File: rtl/par_int_8bit_ctrl.sv
// par_int_8bit_ctrl
//
// Bus controller and two-requester round-robin arbiter for the 8-bit
// parallel interface. It grants one requester at a time and runs a burst of
// len+1 beats, one beat per cycle. It owns the interface direction line
// (w_r_o) and the write-data lines (bus_dout_o). A bus turnaround cycle
// (TURN) can be placed between two transactions whose directions differ.
//
// Build option:
//   PAR_INT_CTRL_TURNAROUND_EN  defined     -> TURN is inserted on every
//                                              direction change.
//                               not defined -> IDLE goes straight to XFER;
//                                              w_r_o switches on the grant
//                                              edge.
//
// Ports:
//   clk_i         system clock, all state on rising edge
//   rst_ni        asynchronous active-low reset
//   req_i[1:0]    per-requester request level, held until done
//   req_wr_i[1:0] per-requester direction (1 = write to bus, 0 = read)
//   req_len0_i    requester 0 burst length minus one, sampled at grant
//   req_len1_i    requester 1 burst length minus one, sampled at grant
//   wdata0_i      requester 0 write data, consumed on each beat_ack
//   wdata1_i      requester 1 write data, consumed on each beat_ack
//   gnt_o[1:0]    one-hot grant, held for the whole transaction
//   beat_ack_o    one pulse per active beat of the granted requester
//   rdata_o       registered read data
//   rvalid_o      rdata_o valid for that requester, one cycle
//   done_o        one-cycle pulse at the end of a transaction
//   busy_o        high in any state other than IDLE
//   w_r_o         bus direction (1 = write, controller drives)
//   bus_en_o      beat strobe to the interface
//   bus_dout_o    write data to the interface, zero unless writing a beat
//   bus_din_i     read data from the interface

module par_int_8bit_ctrl #(
  parameter int DW   = 8,
  parameter int LENW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_i,
  input  logic [1:0]      req_wr_i,
  input  logic [LENW-1:0] req_len0_i,
  input  logic [LENW-1:0] req_len1_i,
  input  logic [DW-1:0]   wdata0_i,
  input  logic [DW-1:0]   wdata1_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      beat_ack_o,
  output logic [DW-1:0]   rdata_o,
  output logic [1:0]      rvalid_o,
  output logic [1:0]      done_o,
  output logic            busy_o,
  output logic            w_r_o,
  output logic            bus_en_o,
  output logic [DW-1:0]   bus_dout_o,
  input  logic [DW-1:0]   bus_din_i
);

`ifdef PAR_INT_CTRL_TURNAROUND_EN
  localparam bit TurnEn = 1'b1;
`else
  localparam bit TurnEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            sel_q, sel_d;     // index of the granted requester
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            w_r_q, w_r_d;
  logic            ptr_q, ptr_d;     // requester favoured when both ask
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rvalid_q, rvalid_d;

  // Arbitration: a lone requester always wins; a tie goes to the pointer.
  logic any_req;
  logic win;

  always_comb begin
    any_req = |req_i;
    if (req_i == 2'b11) begin
      win = ptr_q;
    end else begin
      win = req_i[1];
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    w_r_d    = w_r_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d = win ? 2'b10 : 2'b01;
          sel_d = win;
          len_d = win ? req_len1_i : req_len0_i;
          cnt_d = '0;
          // Direction switches on the grant edge, so during TURN the bus is
          // already pointed the new way but nothing is strobed yet.
          w_r_d = req_wr_i[win];
          if (TurnEn && (req_wr_i[win] != w_r_q)) begin
            state_d = TURN;
          end else begin
            state_d = XFER;
          end
        end
      end

      TURN: begin
        state_d = XFER;
      end

      XFER: begin
        if (!w_r_q) begin
          rdata_d  = bus_din_i;
          rvalid_d = gnt_q;
        end
        // Counter stops at len, so a full 2^LENW-beat burst never wraps.
        if (cnt_q == len_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + LENW'(1);
        end
      end

      DONE: begin
        gnt_d   = 2'b00;
        ptr_d   = ~sel_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      sel_q    <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      w_r_q    <= 1'b0;
      ptr_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      w_r_q    <= w_r_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Beat-level outputs decode directly from the registered state so they
  // line up with the beat cycle itself.
  logic in_xfer;

  always_comb begin
    in_xfer    = (state_q == XFER);
    gnt_o      = gnt_q;
    beat_ack_o = in_xfer ? gnt_q : 2'b00;
    done_o     = (state_q == DONE) ? gnt_q : 2'b00;
    busy_o     = (state_q != IDLE);
    w_r_o      = w_r_q;
    bus_en_o   = in_xfer;
    rdata_o    = rdata_q;
    rvalid_o   = rvalid_q;
    if (in_xfer && w_r_q) begin
      bus_dout_o = sel_q ? wdata1_i : wdata0_i;
    end else begin
      bus_dout_o = '0;
    end
  end

endmodule
